// File: rtl/ext_arbiter_pkg.sv
// Shared types and widths for the two-requester extension-unit arbiter.
// Holds the FSM state enum, data widths and the request bundle.
package ext_arbiter_pkg;

  localparam int WORD_W  = 32;
  localparam int FUNC3_W = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0]  a;
    logic [WORD_W-1:0]  b;
    logic [FUNC3_W-1:0] func3;
  } req_t;

endpackage

// File: rtl/ext_req_buf.sv
// Per-requester pending flag plus operand/func3 capture buffer.
// Ports: clk, rst_n, i_start, i_req, i_clr -> o_pending, o_req.
module ext_req_buf
  import ext_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  req_t i_req,
  input  logic i_clr,
  output logic o_pending,
  output req_t o_req
);

  logic r_pending;
  req_t r_req;
  logic w_accept;

  // A start on the clearing edge is accepted.
  assign w_accept = i_start & (~r_pending | i_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_req     <= '0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
      r_req     <= i_req;
    end else if (i_clr) begin
      r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_req     = r_req;

endmodule

// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one extension unit between two requesters.
// Ports: clk/rst, r0*/r1* request+result, ext* unit side, busy, grant.
module ext_arbiter
  import ext_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r0Start,
  input  logic [WORD_W-1:0]  r0A,
  input  logic [WORD_W-1:0]  r0B,
  input  logic [FUNC3_W-1:0] r0Func3,
  output logic               r0Done,
  output logic [WORD_W-1:0]  r0R,
  output logic               r0Err,
  input  logic               r1Start,
  input  logic [WORD_W-1:0]  r1A,
  input  logic [WORD_W-1:0]  r1B,
  input  logic [FUNC3_W-1:0] r1Func3,
  output logic               r1Done,
  output logic [WORD_W-1:0]  r1R,
  output logic               r1Err,
  output logic               extStart,
  output logic [WORD_W-1:0]  extA,
  output logic [WORD_W-1:0]  extB,
  output logic [FUNC3_W-1:0] extFunc3,
  input  logic               extDone,
  input  logic [WORD_W-1:0]  extR,
  output logic               busy,
  output logic               grant
);

  localparam logic [CNT_W-1:0] LP_TMO_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_grant;
  logic             r_pri;
  req_t             r_ext;
  logic [WORD_W-1:0] r_r0;
  logic [WORD_W-1:0] r_r1;
  logic             r_done0;
  logic             r_done1;
  logic             r_err0;
  logic             r_err1;

  req_t w_in0;
  req_t w_in1;
  req_t w_buf0;
  req_t w_buf1;
  logic w_pend0;
  logic w_pend1;
  logic w_any;
  logic w_pick;
  logic w_load;
  logic w_ok;
  logic w_tmo;
  logic w_fin;
  logic w_clr0;
  logic w_clr1;
  logic w_start;
  logic w_busy;

  assign w_in0 = {r0A, r0B, r0Func3};
  assign w_in1 = {r1A, r1B, r1Func3};

  ext_req_buf u_buf0 (
    .clk       (clk),
    .rst_n     (rst),
    .i_start   (r0Start),
    .i_req     (w_in0),
    .i_clr     (w_clr0),
    .o_pending (w_pend0),
    .o_req     (w_buf0)
  );

  ext_req_buf u_buf1 (
    .clk       (clk),
    .rst_n     (rst),
    .i_start   (r1Start),
    .i_req     (w_in1),
    .i_clr     (w_clr1),
    .o_pending (w_pend1),
    .o_req     (w_buf1)
  );

  assign w_any  = w_pend0 | w_pend1;
  // r_pri names the favoured requester on contention.
  assign w_pick = (w_pend0 & w_pend1) ? r_pri : w_pend1;
  assign w_load = (r_state == IDLE) & w_any;

  // Unit completion beats a coincident timeout.
  assign w_ok  = (r_state == WAIT) & extDone;
  assign w_tmo = (r_state == WAIT) & ~extDone &
                 (r_cnt == LP_TMO_LAST);
  assign w_fin = w_ok | w_tmo;

  assign w_clr0 = w_fin & ~r_grant;
  assign w_clr1 = w_fin &  r_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_any) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_start     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_fin) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_grant <= 1'b0;
      r_pri   <= 1'b0;
      r_ext   <= '0;
      r_r0    <= '0;
      r_r1    <= '0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      if (w_load) begin
        r_grant <= w_pick;
        r_pri   <= ~w_pick;
        r_ext   <= w_pick ? w_buf1 : w_buf0;
      end
      if (r_state == ISSUE) begin
        r_cnt <= '0;
      end else if ((r_state == WAIT) && !extDone) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fin) begin
        if (r_grant) begin
          r_r1    <= w_ok ? extR : '0;
          r_done1 <= 1'b1;
          r_err1  <= w_tmo;
        end else begin
          r_r0    <= w_ok ? extR : '0;
          r_done0 <= 1'b1;
          r_err0  <= w_tmo;
        end
      end
    end
  end

  assign extStart = w_start;
  assign extA     = r_ext.a;
  assign extB     = r_ext.b;
  assign extFunc3 = r_ext.func3;
  assign busy     = w_busy;
  assign grant    = r_grant;
  assign r0Done   = r_done0;
  assign r0Err    = r_err0;
  assign r0R      = r_r0;
  assign r1Done   = r_done1;
  assign r1Err    = r_err1;
  assign r1R      = r_r1;

endmodule

// File: tb/tb_ext_arbiter.sv
// Directed self-checking bench for ext_arbiter (TIMEOUT=8).
// Drives #1 after posedge, samples on negedge.
module tb_ext_arbiter;

  logic        clk;
  logic        rst;
  logic        r0Start;
  logic [31:0] r0A;
  logic [31:0] r0B;
  logic [2:0]  r0Func3;
  logic        r0Done;
  logic [31:0] r0R;
  logic        r0Err;
  logic        r1Start;
  logic [31:0] r1A;
  logic [31:0] r1B;
  logic [2:0]  r1Func3;
  logic        r1Done;
  logic [31:0] r1R;
  logic        r1Err;
  logic        extStart;
  logic [31:0] extA;
  logic [31:0] extB;
  logic [2:0]  extFunc3;
  logic        extDone;
  logic [31:0] extR;
  logic        busy;
  logic        grant;

  int n_chk;
  int n_err;

  ext_arbiter #(.TIMEOUT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .r0Start  (r0Start),
    .r0A      (r0A),
    .r0B      (r0B),
    .r0Func3  (r0Func3),
    .r0Done   (r0Done),
    .r0R      (r0R),
    .r0Err    (r0Err),
    .r1Start  (r1Start),
    .r1A      (r1A),
    .r1B      (r1B),
    .r1Func3  (r1Func3),
    .r1Done   (r1Done),
    .r1R      (r1R),
    .r1Err    (r1Err),
    .extStart (extStart),
    .extA     (extA),
    .extB     (extB),
    .extFunc3 (extFunc3),
    .extDone  (extDone),
    .extR     (extR),
    .busy     (busy),
    .grant    (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic start0(logic [31:0] a, logic [31:0] b,
                        logic [2:0] f);
    r0Start = 1'b1; r0A = a; r0B = b; r0Func3 = f;
    tick();
    r0Start = 1'b0;
  endtask

  task automatic start1(logic [31:0] a, logic [31:0] b,
                        logic [2:0] f);
    r1Start = 1'b1; r1A = a; r1B = b; r1Func3 = f;
    tick();
    r1Start = 1'b0;
  endtask

  // Leaves time at the negedge of the ISSUE cycle.
  task automatic wait_start(string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!extStart && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(extStart), 32'd1);
  endtask

  // From ISSUE: spend lat extra WAIT cycles, then pulse extDone.
  task automatic finish_req(logic [31:0] res, int lat);
    tick();
    repeat (lat) tick();
    extDone = 1'b1;
    extR    = res;
    tick();
    extDone = 1'b0;
    extR    = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    r0Start = 1'b0; r0A = '0; r0B = '0; r0Func3 = '0;
    r1Start = 1'b0; r1A = '0; r1B = '0; r1Func3 = '0;
    extDone = 1'b0; extR = '0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_start", 32'(extStart), 32'd0);
    chk("rst_extA", extA, 32'd0);
    chk("rst_r0R", r0R, 32'd0);
    chk("rst_r1Done", 32'(r1Done), 32'd0);
    tick();
    rst = 1'b1;

    // Single request 7*6
    start0(32'd7, 32'd6, 3'd0);
    @(negedge clk);
    chk("s1_pre_start", 32'(extStart), 32'd0);
    @(negedge clk);
    chk("s1_start", 32'(extStart), 32'd1);
    chk("s1_extA", extA, 32'd7);
    chk("s1_extB", extB, 32'd6);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_grant", 32'(grant), 32'd0);
    @(negedge clk);
    chk("s1_start_1cyc", 32'(extStart), 32'd0);
    chk("s1_hold_extA", extA, 32'd7);
    #1;
    extDone = 1'b1; extR = 32'd42;
    tick();
    extDone = 1'b0; extR = '0;
    @(negedge clk);
    chk("s1_r0Done", 32'(r0Done), 32'd1);
    chk("s1_r0R", r0R, 32'd42);
    chk("s1_r0Err", 32'(r0Err), 32'd0);
    chk("s1_r1Done", 32'(r1Done), 32'd0);
    chk("s1_busy_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("s1_done_pulse", 32'(r0Done), 32'd0);
    chk("s1_r0R_hold", r0R, 32'd42);

    // Simultaneous pair after reset
    #1;
    do_reset();
    r0Start = 1'b1; r0A = 32'd3; r0B = 32'd5;
    r1Start = 1'b1; r1A = 32'd4; r1B = 32'd4;
    tick();
    r0Start = 1'b0; r1Start = 1'b0;
    wait_start("s2_a_start");
    chk("s2_a_grant", 32'(grant), 32'd0);
    chk("s2_a_extA", extA, 32'd3);
    finish_req(32'd15, 1);
    @(negedge clk);
    chk("s2_a_r0Done", 32'(r0Done), 32'd1);
    chk("s2_a_r0R", r0R, 32'd15);
    chk("s2_a_r1Done", 32'(r1Done), 32'd0);
    wait_start("s2_b_start");
    chk("s2_b_grant", 32'(grant), 32'd1);
    chk("s2_b_extA", extA, 32'd4);
    finish_req(32'd16, 0);
    @(negedge clk);
    chk("s2_b_r1Done", 32'(r1Done), 32'd1);
    chk("s2_b_r1R", r1R, 32'd16);
    #1;
    start0(32'd2, 32'd2, 3'd0);
    wait_start("s2_c_start");
    chk("s2_c_grant", 32'(grant), 32'd0);
    finish_req(32'd4, 0);
    @(negedge clk);
    chk("s2_c_r0R", r0R, 32'd4);
    #1;
    r0Start = 1'b1; r0A = 32'd6; r0B = 32'd7;
    r1Start = 1'b1; r1A = 32'd8; r1B = 32'd8;
    tick();
    r0Start = 1'b0; r1Start = 1'b0;
    wait_start("s2_d_start");
    chk("s2_d_grant", 32'(grant), 32'd1);
    chk("s2_d_extA", extA, 32'd8);
    finish_req(32'd64, 0);
    @(negedge clk);
    chk("s2_d_r1R", r1R, 32'd64);
    chk("s2_d_r1Done", 32'(r1Done), 32'd1);
    wait_start("s2_e_start");
    chk("s2_e_grant", 32'(grant), 32'd0);
    chk("s2_e_extA", extA, 32'd6);
    finish_req(32'd42, 0);
    @(negedge clk);
    chk("s2_e_r0R", r0R, 32'd42);

    // r1 queued behind r0 in WAIT
    #1;
    start0(32'd2, 32'd3, 3'd0);
    wait_start("s3_r0_start");
    tick();
    r1Start = 1'b1; r1A = 32'd9; r1B = 32'd9;
    tick();
    r1Start = 1'b0;
    extDone = 1'b1; extR = 32'd6;
    tick();
    extDone = 1'b0; extR = '0;
    @(negedge clk);
    chk("s3_r0Done", 32'(r0Done), 32'd1);
    chk("s3_r0R", r0R, 32'd6);
    chk("s3_no_start", 32'(extStart), 32'd0);
    @(negedge clk);
    chk("s3_r1_start", 32'(extStart), 32'd1);
    chk("s3_r1_grant", 32'(grant), 32'd1);
    chk("s3_r1_extA", extA, 32'd9);
    finish_req(32'd81, 0);
    @(negedge clk);
    chk("s3_r1Done", 32'(r1Done), 32'd1);
    chk("s3_r1R", r1R, 32'd81);

    // Timeout, TIMEOUT=8
    #1;
    start0(32'd5, 32'd5, 3'd0);
    wait_start("s4_start");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("s4_wait_done", 32'(r0Done), 32'd0);
      chk("s4_wait_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("s4_r0Done", 32'(r0Done), 32'd1);
    chk("s4_r0Err", 32'(r0Err), 32'd1);
    chk("s4_r0R", r0R, 32'd0);
    @(negedge clk);
    chk("s4_busy", 32'(busy), 32'd0);
    chk("s4_err_pulse", 32'(r0Err), 32'd0);
    chk("s4_done_pulse", 32'(r0Done), 32'd0);

    // Repeat start while pending is ignored
    #1;
    start0(32'd4, 32'd5, 3'd2);
    r0Start = 1'b1; r0A = 32'd1; r0B = 32'd1; r0Func3 = 3'd7;
    tick();
    r0Start = 1'b0;
    wait_start("s6_start");
    chk("s6_extA", extA, 32'd4);
    chk("s6_extB", extB, 32'd5);
    chk("s6_func3", 32'(extFunc3), 32'd2);
    finish_req(32'd20, 1);
    @(negedge clk);
    chk("s6_r0Done", 32'(r0Done), 32'd1);
    chk("s6_r0R", r0R, 32'd20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s6_no_reissue", 32'(busy), 32'd0);
    end

    // Reset during WAIT, stale extDone afterwards
    #1;
    start1(32'd2, 32'd2, 3'd0);
    wait_start("s5_start");
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_grant", 32'(grant), 32'd0);
    chk("s5_extA", extA, 32'd0);
    chk("s5_r1R", r1R, 32'd0);
    chk("s5_r0R", r0R, 32'd0);
    tick();
    rst = 1'b1;
    extDone = 1'b1; extR = 32'd99;
    tick();
    extDone = 1'b0; extR = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s5_r1Done", 32'(r1Done), 32'd0);
      chk("s5_r1R_zero", r1R, 32'd0);
      chk("s5_idle", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
